uparc_iter_mul: RTL and testbench

//  Parametrised iterative integer multiplier/accumulator for the EX-stage MULT/MULTU/MADD/MSUB path.

---
 rtl/uparc_iter_mul_pkg.sv | 21 ++
 rtl/uparc_mul_step.sv | 27 ++
 rtl/uparc_iter_mul.sv | 137 +++++++++++++
 tb/tb_uparc_iter_mul.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uparc_iter_mul_pkg.sv
// Purpose: shared opcodes, FSM state encoding and helpers for the iterative
//          MULT/MULTU/MADD/MSUB unit.
// Contents: mul operation codes, mul_state_e, mul_op_norm().
package uparc_iter_mul_pkg;

    localparam logic [1:0] UPARC_MUL_OP_MUL  = 2'd0;
    localparam logic [1:0] UPARC_MUL_OP_MADD = 2'd1;
    localparam logic [1:0] UPARC_MUL_OP_MSUB = 2'd2;

    typedef enum logic [1:0] {
        MUL_ST_IDLE = 2'd0,
        MUL_ST_RUN  = 2'd1,
        MUL_ST_FIN  = 2'd2
    } mul_state_e;

    // The reserved encoding 2'b11 executes as a plain multiply.
    function automatic logic [1:0] mul_op_norm(input logic [1:0] op);
        return (op == 2'b11) ? UPARC_MUL_OP_MUL : op;
    endfunction

endpackage

// File: rtl/uparc_mul_step.sv
// Purpose: one radix-2^RADIX_BITS shift-add iteration of the multiplier.
// Ports:
//   prod_i  in  2*WIDTH  {partial high, remaining multiplier bits}
//   a_i     in  WIDTH    unsigned multiplicand magnitude
//   prod_o  out 2*WIDTH  partial product after retiring RADIX_BITS bits
module uparc_mul_step #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int unsigned SW = WIDTH + RADIX_BITS;

    logic [RADIX_BITS-1:0] digit;
    logic [SW-1:0]         sum;

    // Sum is W+R bits wide so the carry-out lands in the shifted high half.
    always_comb begin
        digit  = prod_i[RADIX_BITS-1:0];
        sum    = SW'(prod_i[2*WIDTH-1:WIDTH]) + SW'(a_i) * SW'(digit);
        prod_o = {sum, prod_i[WIDTH-1:RADIX_BITS]};
    end

endmodule

// File: rtl/uparc_iter_mul.sv
// Purpose: iterative integer multiplier/accumulator for the EX-stage
//          MULT/MULTU/MADD/MSUB path, RADIX_BITS multiplier bits per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           launch (aborts any operation in flight)
//   signd           two's-complement operands when 1
//   op              MUL / MADD / MSUB (2'b11 behaves as MUL)
//   multiplicand    operand A, multiplier operand B
//   acc_in          {HI,LO} accumulator for MADD/MSUB
//   ready           combinational: idle and no start this cycle
//   done            one-cycle pulse when result updates
//   result          2*WIDTH result, held until the next done
module uparc_iter_mul
    import uparc_iter_mul_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signd,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned N  = WIDTH / RADIX_BITS;
    localparam int unsigned CW = $clog2(N + 1);

    mul_state_e      state_q;
    logic [W-1:0]    a_q;
    logic [PW-1:0]   prod_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   result_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic            neg_q;
    logic            done_q;

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic            zero_op;
    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   p_fin;
    logic [PW-1:0]   result_d;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1) as an unsigned W-bit value.
    always_comb begin
        a_neg   = signd & multiplicand[W-1];
        b_neg   = signd & multiplier[W-1];
        a_abs   = a_neg ? W'(-multiplicand) : multiplicand;
        b_abs   = b_neg ? W'(-multiplier)   : multiplier;
        zero_op = (multiplicand == '0) || (multiplier == '0);
    end

    uparc_mul_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .prod_i (prod_q),
        .a_i    (a_q),
        .prod_o (prod_d)
    );

    // Sign fix-up and accumulate, used in the FIN cycle.
    always_comb begin
        p_fin    = neg_q ? PW'(-prod_q) : prod_q;
        result_d = p_fin;
        case (op_q)
            UPARC_MUL_OP_MADD: result_d = acc_q + p_fin;
            UPARC_MUL_OP_MSUB: result_d = acc_q - p_fin;
            default:           result_d = p_fin;
        endcase
    end

    // Control FSM with operand latches; start overrides any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_ST_IDLE;
            a_q      <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_q   <= a_abs;
                acc_q <= acc_in;
                op_q  <= mul_op_norm(op);
                neg_q <= signd & (multiplicand[W-1] ^ multiplier[W-1]);
                if (zero_op) begin
                    prod_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= MUL_ST_FIN;
                end else begin
                    prod_q  <= {{W{1'b0}}, b_abs};
                    cnt_q   <= CW'(N);
                    state_q <= MUL_ST_RUN;
                end
            end else begin
                case (state_q)
                    MUL_ST_RUN: begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= MUL_ST_FIN;
                        end
                    end
                    MUL_ST_FIN: begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= MUL_ST_IDLE;
                    end
                    default: state_q <= MUL_ST_IDLE;
                endcase
            end
        end
    end

    assign ready  = (state_q == MUL_ST_IDLE) && !start;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_uparc_iter_mul.sv
// Self-checking bench for uparc_iter_mul (WIDTH=32): directed vector table,
// hand-written abort/reset/back-to-back sequences and random operations,
// all checked through a due-cycle scoreboard.
module tb_uparc_iter_mul;

    localparam int RADIX = 2;
    localparam int N     = 32 / RADIX;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signd;
    logic [1:0]  op;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] acc_in;
    logic        ready;
    logic        done;
    logic [63:0] result;

    uparc_iter_mul #(
        .WIDTH      (32),
        .RADIX_BITS (RADIX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signd        (signd),
        .op           (op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .acc_in       (acc_in),
        .ready        (ready),
        .done         (done),
        .result       (result)
    );

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    typedef struct {
        logic        s;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] exp;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic s, input logic [1:0] o,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] acc);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (o)
            2'd1:    return acc + p;
            2'd2:    return acc - p;
            default: return p;
        endcase
    endfunction

    // Scoreboard: every done must match the oldest live entry, in its due cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) check("done_twice", 64'(1), 64'(0));
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got result %h with nothing pending (cycle %0d)", result, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", result, mon_e.res);
                    check("done_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_done: no done in cycle %0d, expected result %h", mon_e.due, mon_e.res);
            end
            prev_done = done;
        end
    end

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one start cycle, retire aborted entries, then scramble inputs.
    task automatic launch(input logic s, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] acc, input logic [63:0] expv);
        int   t;
        exp_t e;
        t = cyc;
        while (sb_q.size() > 0 && sb_q[sb_q.size()-1].due > t) void'(sb_q.pop_back());
        signd        = s;
        op           = o;
        multiplicand = a;
        multiplier   = b;
        acc_in       = acc;
        start        = 1'b1;
        e.res = expv;
        e.due = ((a == 0) || (b == 0)) ? t + 2 : t + N + 2;
        sb_q.push_back(e);
        step_n(1);
        start        = 1'b0;
        signd        = 1'($urandom);
        op           = 2'($urandom);
        multiplicand = $urandom;
        multiplier   = $urandom;
        acc_in       = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (sb_q.size() > 0 && i < 4 * N + 20) begin
            step_n(1);
            i++;
        end
        total++;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL idle_timeout: %0d ops still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_n(1);
        rst = 1'b0;
        sb_q.delete();
        check("rst_result", result, 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_ready", 64'(ready), 64'h1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d1;
        logic        rs;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] racc;

        vecs[0]  = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 2'd0, 32'hFFFF_FFFD, 32'h7, 64'h0, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2]  = '{1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
        vecs[3]  = '{1'b0, 2'd1, 32'h2, 32'h3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0006};
        vecs[4]  = '{1'b0, 2'd2, 32'h2, 32'h3, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFA};
        vecs[5]  = '{1'b0, 2'd1, 32'h0, 32'h5, 64'h1234, 64'h1234};
        vecs[6]  = '{1'b0, 2'd0, 32'hFFFF_FFFD, 32'h7, 64'h0, 64'h0000_0006_FFFF_FFEB};
        vecs[7]  = '{1'b0, 2'd3, 32'h6, 32'h7, 64'hFFFF, 64'h2A};
        vecs[8]  = '{1'b1, 2'd2, 32'hFFFF_FFFE, 32'h3, 64'h0, 64'h6};
        vecs[9]  = '{1'b1, 2'd1, 32'h5, 32'hFFFF_FFFF, 64'hA, 64'h5};
        vecs[10] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 64'h7, 64'h7};
        vecs[11] = '{1'b0, 2'd0, 32'h1, 32'h1, 64'h0, 64'h1};
        vecs[12] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'h1};

        rst          = 1'b1;
        start        = 1'b0;
        signd        = 1'b0;
        op           = 2'd0;
        multiplicand = 32'h0;
        multiplier   = 32'h0;
        acc_in       = 64'h0;
        step_n(2);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].s, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].exp);
            wait_idle();
        end

        // Zero fast path: FIN next cycle, done and ready in the cycle after.
        launch(1'b0, 2'd1, 32'h0, 32'h5, 64'h1234, 64'h1234);
        check("zero_ready_busy", 64'(ready), 64'h0);
        step_n(1);
        check("zero_done", 64'(done), 64'h1);
        check("zero_ready", 64'(ready), 64'h1);
        wait_idle();

        // Busy during RUN, then restart at t+3: only the second op completes.
        launch(1'b0, 2'd0, 32'h5, 32'h5, 64'h0, 64'h19);
        check("run_ready", 64'(ready), 64'h0);
        step_n(2);
        launch(1'b0, 2'd0, 32'h6, 32'h7, 64'h0, 64'h2A);
        wait_idle();
        check("abort_result", result, 64'h2A);

        // Restart while in FIN: the first op never delivers.
        d1 = cyc + N + 2;
        launch(1'b0, 2'd0, 32'h9, 32'h9, 64'h0, 64'h51);
        while (cyc < d1 - 1) step_n(1);
        launch(1'b0, 2'd0, 32'h3, 32'h4, 64'h0, 64'hC);
        wait_idle();

        // Reset mid-RUN: no done, result cleared, no late done afterwards.
        launch(1'b0, 2'd0, 32'h1234, 32'h5678, 64'h0, 64'h0);
        step_n(3);
        do_reset();
        step_n(N + 4);

        // Back-to-back: second start in the done cycle of the first.
        d1 = cyc + N + 2;
        launch(1'b0, 2'd0, 32'h2, 32'h3, 64'h0, 64'h6);
        while (cyc < d1) step_n(1);
        launch(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h4, 64'h10, 64'hC);
        wait_idle();

        // Random operations with random gaps; short gaps exercise aborts.
        for (int i = 0; i < 400; i++) begin
            rs   = 1'($urandom);
            ro   = 2'($urandom);
            ra   = pick();
            rb   = pick();
            racc = {$urandom, $urandom};
            launch(rs, ro, ra, rb, racc, ref_model(rs, ro, ra, rb, racc));
            step_n($urandom_range(0, N + 4));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
